// File: rtl/perip_reg_fifo_bank_if.sv
// System-bus side of the peripheral register bank: strobes, byte enables,
// address and data in both directions.
interface perip_reg_fifo_bank_if;
  logic        write_bus;
  logic        read_bus;
  logic [3:0]  be_bus;
  logic [31:0] addr_bus;
  logic [31:0] data_i_bus;
  logic [31:0] data_o_bus;

  modport master (
    output write_bus, read_bus, be_bus, addr_bus, data_i_bus,
    input  data_o_bus
  );

  modport slave (
    input  write_bus, read_bus, be_bus, addr_bus, data_i_bus,
    output data_o_bus
  );
endinterface

// File: rtl/perip_reg_fifo_bank.sv
// Peripheral register bank: NREG general registers shared by bus and core,
// sticky W1C status, interrupt enables with registered irq, and an RX FIFO.
module perip_reg_fifo_bank #(
  parameter int              NREG        = 4,
  parameter logic [NREG-1:0] ALLOW_WRITE = {NREG{1'b1}},
  parameter int              STA_W       = 8,
  parameter int              FIFO_DEPTH  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  perip_reg_fifo_bank_if.slave bus,
  input  logic                write_perip,
  input  logic [31:0]         wraddr_perip,
  input  logic [31:0]         data_i_perip,
  input  logic [31:0]         rdaddr_perip,
  output logic [31:0]         data_o_perip,
  input  logic [STA_W-1:0]    sta_set_i,
  input  logic                rx_push_i,
  input  logic [31:0]         rx_data_i,
  output logic                rx_full_o,
  output logic [31:0]         ctrl_o,
  output logic                irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [29:0] STA_A = 30'(NREG);
  localparam logic [29:0] IEN_A = 30'(NREG + 1);
  localparam logic [29:0] RXD_A = 30'(NREG + 2);
  localparam logic [29:0] RXS_A = 30'(NREG + 3);

  logic [29:0] bus_word, wr_word, rd_word;
  logic [31:0] lane_mask;
  logic        unused_addr_bits;

  assign bus_word  = bus.addr_bus[31:2];
  assign wr_word   = wraddr_perip[31:2];
  assign rd_word   = rdaddr_perip[31:2];
  assign lane_mask = {{8{bus.be_bus[3]}}, {8{bus.be_bus[2]}},
                      {8{bus.be_bus[1]}}, {8{bus.be_bus[0]}}};
  assign unused_addr_bits = ^{bus.addr_bus[1:0], wraddr_perip[1:0], rdaddr_perip[1:0]};

  // General registers: peripheral writes the whole word, bus bytes override it
  logic [NREG-1:0][31:0] regs_q;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [31:0] q_reg, q_next;

      always_comb begin
        q_next = q_reg;
        if (write_perip && wr_word == 30'(gi))
          q_next = data_i_perip;
        if (ALLOW_WRITE[gi] && bus.write_bus && bus_word == 30'(gi))
          q_next = (q_next & ~lane_mask) | (bus.data_i_bus & lane_mask);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_reg <= '0;
        else       q_reg <= q_next;
      end

      assign regs_q[gi] = q_reg;
    end
  endgenerate

  logic [STA_W-1:0] sta_reg, sta_next, sta_clr;
  logic [31:0]      ien_reg, ien_next;

  always_comb begin
    sta_clr = '0;
    if (bus.write_bus && bus_word == STA_A)
      sta_clr = bus.data_i_bus[STA_W-1:0] & lane_mask[STA_W-1:0];
    sta_next = (sta_reg & ~sta_clr) | sta_set_i;

    ien_next = ien_reg;
    if (bus.write_bus && bus_word == IEN_A)
      ien_next = (ien_reg & ~lane_mask) | (bus.data_i_bus & lane_mask);
  end

  // RX FIFO; a pop frees a slot in the same cycle, so push+pop when full is legal
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          empty_reg, full_reg, ovf_reg, ovf_next;
  logic          pop, push, ovf_set, ovf_clr, irq_reg, irq_next;

  always_comb begin
    pop        = bus.read_bus && bus_word == RXD_A && !empty_reg;
    push       = rx_push_i && (!full_reg || pop);
    ovf_set    = rx_push_i && full_reg && !pop;
    ovf_clr    = bus.write_bus && bus_word == RXS_A && bus.be_bus[2] && bus.data_i_bus[18];
    level_next = level_reg + LW'(push) - LW'(pop);
    ovf_next   = ovf_set | (ovf_reg & ~ovf_clr);
    irq_next   = (|(sta_reg & ien_reg[STA_W-1:0])) | (ien_reg[30] & ovf_reg)
               | (ien_reg[31] & ~empty_reg);
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= rx_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sta_reg    <= '0;
      ien_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      sta_reg   <= sta_next;
      ien_reg   <= ien_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
      empty_reg <= (level_next == '0);
      full_reg  <= (level_next == LW'(FIFO_DEPTH));
      ovf_reg   <= ovf_next;
      irq_reg   <= irq_next;
    end
  end

  function automatic logic [31:0] read_word(input logic [29:0] w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++)
      if (w == 30'(i)) v = regs_q[i];
    if (w == STA_A) v = 32'(sta_reg);
    if (w == IEN_A) v = ien_reg;
    if (w == RXD_A) v = empty_reg ? 32'd0 : fifo_mem[rd_ptr_reg];
    if (w == RXS_A) v = {13'd0, ovf_reg, full_reg, empty_reg, 16'(level_reg)};
    return v;
  endfunction

  always_comb begin
    bus.data_o_bus = read_word(bus_word);
    data_o_perip   = read_word(rd_word);
  end

  assign ctrl_o    = regs_q[0];
  assign irq_o     = irq_reg;
  assign rx_full_o = full_reg;
endmodule

// File: doc/perip_reg_fifo_bank.md
Name: perip_reg_fifo_bank

Overview:
Parametrised successor to the per-peripheral memory-mapped register bank. It holds NREG general registers, writable from both the system bus (byte-enabled) and the peripheral core. It adds sticky write-1-to-clear status, an interrupt-enable mask with a registered irq_o, and an RX FIFO that the peripheral pushes into and the bus pops by reading. It sits between the bus slave decode and any serial peripheral core (USB, UART, SPI).

Parameters:
NREG, 4, number of general registers (>=1); word addresses 0..NREG-1
ALLOW_WRITE, {NREG{1'b1}}, bit i=1: general register i is bus-writable
STA_W, 8, number of sticky status bits (1..16)
FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..1024

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
write_bus  in  1  bus write strobe
read_bus  in  1  bus read strobe (only used for FIFO pop)
be_bus  in  4  bus byte enables
addr_bus  in  32  bus byte address; word index = addr_bus[31:2]
data_i_bus  in  32  bus write data
data_o_bus  out  32  bus read data, combinational
write_perip  in  1  peripheral write strobe
wraddr_perip  in  32  peripheral write byte address
data_i_perip  in  32  peripheral write data, full word
rdaddr_perip  in  32  peripheral read byte address
data_o_perip  out  32  peripheral read data, combinational
sta_set_i  in  STA_W  per-bit status set pulses
rx_push_i  in  1  push rx_data_i into the FIFO
rx_data_i  in  32  FIFO push data
rx_full_o  out  1  FIFO full, registered
ctrl_o  out  32  current value of general register 0
irq_o  out  1  interrupt, registered

Behaviour:
- Word map: 0..NREG-1 general registers; NREG STA; NREG+1 IEN; NREG+2 RXDATA; NREG+3 RXSTAT. Above NREG+3: reads return 0, writes ignored.
- General registers:
  - Peripheral write sets the full word.
  - Bus write is byte-laned by be_bus, and only applies where ALLOW_WRITE[i]=1.
  - Bus and peripheral writing the same register in the same cycle: bus-enabled bytes take bus data; the other bytes take peripheral data.
  - Peripheral writes to addresses >= NREG are ignored.
- STA[STA_W-1:0] bits are sticky:
  - Bit set when sta_set_i[i]=1.
  - Cleared by a bus write with data 1 in bit i, for bits inside an enabled byte lane.
  - Set beats clear in the same cycle.
  - Upper bits read 0.
- IEN: plain bus read/write with byte enables.
  - Bits [STA_W-1:0] mask STA.
  - Bit 30 enables the overflow interrupt.
  - Bit 31 enables the FIFO-not-empty interrupt.
  - Other bits are storage only.
- RXDATA:
  - Read returns the FIFO head, or 0 when empty.
  - A pop occurs at the clock edge when read_bus=1, the address matches, and the FIFO is not empty.
  - Writes are ignored.
- RXSTAT layout: [15:0] level, [16] empty, [17] full, [18] ovf (sticky). ovf is W1C via bus bit 18; all other bits are read-only.
- FIFO rules:
  - Push when not full: stores the data; the write pointer wraps modulo FIFO_DEPTH.
  - Push when full with no pop: data dropped, ovf set.
  - Push and pop together when full: both execute, level unchanged, ovf not set.
  - Push and pop together when empty: the pop is ignored and the push is accepted.
  - ovf set beats W1C in the same cycle.
- irq_o is registered: next value = |(STA & IEN[STA_W-1:0]) | (IEN[30] & ovf) | (IEN[31] & ~empty). It asserts 1 cycle after the condition becomes true.
- rx_full_o reflects the registered full flag (level==FIFO_DEPTH).
- Reset (async, any time, including mid-transfer):
  - All registers, STA, IEN, pointers, level and ovf go to 0.
  - empty=1; ctrl_o=0, irq_o=0, rx_full_o=0.
  - Combinational outputs follow the reset state: data_o_bus/data_o_perip read 0 for all registers, RXSTAT reads 0x00010000.

Test Plan:
- Reset, then bus write 0xAABBCCDD to reg0 with be=4'b0101 -> reads 0x00BB00DD; ctrl_o=0x00BB00DD the next cycle.
- With ALLOW_WRITE[1]=0: bus write to reg1 -> reads 0. Then peripheral write 0x12345678 to reg1 -> bus reads 0x12345678. Same-cycle bus write reg0 0xFFFFFFFF be=4'b0001 and peripheral write reg0 0x11223344 -> 0x112233FF.
- Pulse sta_set_i=8'h05, IEN=0x00000004 -> STA=0x05, irq_o=1 one cycle later. W1C write 0x04 -> STA=0x01, irq_o=0 the following cycle. Same-cycle set and clear of bit 0 -> bit 0 stays 1.
- Push 0x10..0x17 (depth 8) -> rx_full_o=1, RXSTAT=0x00020008. Push 0x18 -> dropped, ovf=1. Read RXDATA -> 0x10; level=7.
- When full, push 0x99 with a same-cycle pop -> level stays 8, ovf unchanged. Drain all entries -> order 0x11..0x17, then 0x99. Read when empty -> 0, level 0.
- IEN[31]=1, push one word -> irq_o=1 after 1 cycle. Assert rst_i mid-burst -> irq_o, rx_full_o and ctrl_o go 0 immediately; RXSTAT=0x00010000.
